keydemux: RTL

Result router on the return path of the shared alu32. It takes each result the ALU produces, tagged with its transaction key, and delivers it to the client channel that issued that key. It holds the result there until the client acknowledges it. It also returns the completed key as `keyback_o`, which the request-side keyed multiplexer uses to release its next operation.

---
 rtl/keydemux_pkg.sv | 20 ++
 rtl/keydemux_keymatch.sv | 24 ++
 rtl/keydemux.sv | 129 ++++++++++++
 3 files changed

// File: rtl/keydemux_pkg.sv
// keydemux_pkg: shared widths and types for the keydemux result router.
//   KEY_SIZE          width of a transaction key
//   OPERAND_SIZE      width of an ALU operand/result
//   OPCODE_SIZE       width of an ALU opcode (shared with the request side)
//   KEYDEMUX_ORPHAN_W width of the saturating orphan counter
//   ch_state_t        per-channel holding state (EMPTY / FULL)
package keydemux_pkg;

  localparam int KEY_SIZE          = 8;
  localparam int OPERAND_SIZE      = 32;
  localparam int OPCODE_SIZE       = 4;
  localparam int KEYDEMUX_ORPHAN_W = 8;

  // FULL means a result is held for the client and not yet acknowledged.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } ch_state_t;

endpackage

// File: rtl/keydemux_keymatch.sv
// keymatch: combinational lowest-index priority encoder.
//   req   in  n   per-channel match vector
//   owner out n   one-hot grant to the lowest set bit of req (all zero if none)
//   hit   out 1   at least one bit of req is set
module keymatch #(
  parameter int n = 1
) (
  input  logic [n-1:0] req,
  output logic [n-1:0] owner,
  output logic         hit
);

  always_comb begin
    owner = '0;
    hit   = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (req[i] && !hit) begin
        owner[i] = 1'b1;
        hit      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/keydemux.sv
// keydemux: routes keyed ALU results back to the client channel that issued
// the key, holding each result until the client acknowledges it.
//
// Optional feature macro: KEYDEMUX_ORPHAN_EN (orphan flag + saturating count).
//
// Ports:
//   clk           in   1                      system clock (rising edge)
//   rst           in   1                      synchronous reset, active low
//   key_i         in   ninputs*KEY_SIZE       snooped per-channel request keys
//   res_valid_i   in   1                      ALU result strobe
//   res_key_i     in   KEY_SIZE               key echoed with the result
//   res_i         in   OPERAND_SIZE           ALU result
//   ack_i         in   ninputs                per-channel consume acknowledge
//   keyback_o     out  KEY_SIZE               key of last completed result
//   res_o         out  ninputs*OPERAND_SIZE   per-channel held result
//   valid_o       out  ninputs                per-channel result available (state FULL)
//   ovf_o         out  ninputs                per-channel sticky overflow
//   orphan_o      out  1                      sticky unmatched-result flag
//   orphan_cnt_o  out  KEYDEMUX_ORPHAN_W      saturating unmatched-result count
//
// Handshake: a result is accepted on every cycle res_valid_i is 1 (no
// back-pressure). A channel presents valid_o=1 until ack_i is seen high on a
// rising edge; an ack in the same cycle as a new delivery frees the slot for
// that delivery (reload).
`ifndef KEYDEMUX_V
`define KEYDEMUX_V

module keydemux
  import keydemux_pkg::*;
#(
  parameter int ninputs = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [ninputs*KEY_SIZE-1:0]     key_i,
  input  logic                            res_valid_i,
  input  logic [KEY_SIZE-1:0]             res_key_i,
  input  logic [OPERAND_SIZE-1:0]         res_i,
  input  logic [ninputs-1:0]              ack_i,
  output logic [KEY_SIZE-1:0]             keyback_o,
  output logic [ninputs*OPERAND_SIZE-1:0] res_o,
  output logic [ninputs-1:0]              valid_o,
  output logic [ninputs-1:0]              ovf_o,
  output logic                            orphan_o,
  output logic [KEYDEMUX_ORPHAN_W-1:0]    orphan_cnt_o
);

  if (ninputs < 1) begin : g_bad_param
    $error("keydemux: ninputs must be > 0");
  end

  logic [KEY_SIZE-1:0] served_q [ninputs];
  ch_state_t           state_q  [ninputs];
  logic [ninputs-1:0]  match;
  logic [ninputs-1:0]  owner;
  logic                hit;

  // A channel only matches while it still waits on its current key; once
  // served, the same key value cannot claim a second result.
  always_comb begin
    match = '0;
    for (int i = 0; i < ninputs; i++) begin
      match[i] = (key_i[KEY_SIZE*i +: KEY_SIZE] != served_q[i]) &&
                 (key_i[KEY_SIZE*i +: KEY_SIZE] == res_key_i);
    end
  end

  keymatch #(.n(ninputs)) u_keymatch (
    .req   (match),
    .owner (owner),
    .hit   (hit)
  );

  for (genvar g = 0; g < ninputs; g++) begin : g_ch
    logic deliver;
    assign deliver    = res_valid_i && hit && owner[g];
    assign valid_o[g] = (state_q[g] == FULL);

    always_ff @(posedge clk) begin
      if (!rst) begin
        served_q[g]                          <= '0;
        state_q[g]                           <= EMPTY;
        res_o[OPERAND_SIZE*g +: OPERAND_SIZE] <= '0;
        ovf_o[g]                             <= 1'b0;
      end else if (deliver) begin
        served_q[g] <= res_key_i;
        if (state_q[g] == EMPTY || ack_i[g]) begin
          res_o[OPERAND_SIZE*g +: OPERAND_SIZE] <= res_i;
          state_q[g]                           <= FULL;
        end else begin
          // Client has not consumed the held result: keep it, flag the loss.
          ovf_o[g] <= 1'b1;
        end
      end else if (ack_i[g] && state_q[g] == FULL) begin
        state_q[g] <= EMPTY;
      end
    end
  end

  // Every result returns its key, even dropped or orphaned ones, so the
  // request side never waits forever.
  always_ff @(posedge clk) begin
    if (!rst) begin
      keyback_o <= '0;
    end else if (res_valid_i) begin
      keyback_o <= res_key_i;
    end
  end

`ifdef KEYDEMUX_ORPHAN_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      orphan_o     <= 1'b0;
      orphan_cnt_o <= '0;
    end else if (res_valid_i && !hit) begin
      orphan_o <= 1'b1;
      if (orphan_cnt_o != {KEYDEMUX_ORPHAN_W{1'b1}}) begin
        orphan_cnt_o <= orphan_cnt_o + 1'b1;
      end
    end
  end
`else
  assign orphan_o     = 1'b0;
  assign orphan_cnt_o = '0;
`endif

endmodule

`endif
